// File: rtl/trap_redirect_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// trap_redirect_ctrl_pkg
// Shared definitions for the commit-event redirect sequencer:
//   - state_e : sequencer states (IDLE, FLUSH, DRAIN, REDIRECT)
//   - kind_e  : redirect kind reported to fetch (0 miss, 1 trap, 2 ret)
//   - TVEC_MODE_* : trap-vector CSR mode field encodings
// -----------------------------------------------------------------------------
package trap_redirect_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_REDIRECT = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        KIND_MISS = 2'd0,
        KIND_TRAP = 2'd1,
        KIND_RET  = 2'd2
    } kind_e;

    // Only vectored mode changes the target; modes 2/3 fall back to direct.
    localparam logic [1:0] TVEC_MODE_DIRECT   = 2'd0;
    localparam logic [1:0] TVEC_MODE_VECTORED = 2'd1;

endpackage : trap_redirect_ctrl_pkg

// File: rtl/trap_redirect_ctrl_trap_vec_calc.sv
// -----------------------------------------------------------------------------
// trap_vec_calc
// Combinational arbitration of commit-stage control events and computation of
// the redirect target.
//   trap_i / mret_i / sret_i / miss_i : event strobes (priority in that order)
//   trap_is_interrupt_i, trap_to_s_i, ecause_i : trap qualifiers
//   mtvec_i / stvec_i   : trap vector CSRs
//   mepc_i / sepc_i     : return targets
//   miss_pc_i           : corrected fetch target for a mispredict
//   event_o             : at least one strobe present
//   target_o / kind_o   : target and kind of the winning event
// -----------------------------------------------------------------------------
module trap_vec_calc
    import trap_redirect_ctrl_pkg::*;
#(
    parameter int PC_WIDTH              = 39,
    parameter int XLEN                  = 64,
    parameter int EXCEPTION_CAUSE_WIDTH = 4
) (
    input  logic                             trap_i,
    input  logic                             trap_is_interrupt_i,
    input  logic                             trap_to_s_i,
    input  logic [EXCEPTION_CAUSE_WIDTH-1:0] ecause_i,
    input  logic [XLEN-1:0]                  mtvec_i,
    input  logic [XLEN-1:0]                  stvec_i,
    input  logic                             mret_i,
    input  logic                             sret_i,
    input  logic [XLEN-1:0]                  mepc_i,
    input  logic [XLEN-1:0]                  sepc_i,
    input  logic                             miss_i,
    input  logic [PC_WIDTH-1:0]              miss_pc_i,
    output logic                             event_o,
    output logic [PC_WIDTH-1:0]              target_o,
    output kind_e                            kind_o
);

    logic [XLEN-1:0]     tvec_s;
    logic [PC_WIDTH-1:0] vec_base_s;
    logic [PC_WIDTH-1:0] vec_off_s;
    logic [PC_WIDTH-1:0] trap_target_s;
    logic                unused_s;

    assign tvec_s     = trap_to_s_i ? stvec_i : mtvec_i;
    assign vec_base_s = {tvec_s[PC_WIDTH-1:2], 2'b00};
    // Vector offset is cause*4; the sum below wraps modulo 2^PC_WIDTH.
    assign vec_off_s  = {{(PC_WIDTH-EXCEPTION_CAUSE_WIDTH-2){1'b0}}, ecause_i, 2'b00};
    assign event_o    = trap_i | mret_i | sret_i | miss_i;

    // CSR bits above the PC width and epc alignment bits play no part in the target.
    assign unused_s = ^{tvec_s[XLEN-1:PC_WIDTH], mepc_i[XLEN-1:PC_WIDTH], mepc_i[1:0],
                        sepc_i[XLEN-1:PC_WIDTH], sepc_i[1:0]};

    // Trap target: vectored interrupts add the cause offset, everything else is direct.
    always_comb begin
        trap_target_s = vec_base_s;
        if ((tvec_s[1:0] == TVEC_MODE_VECTORED) && trap_is_interrupt_i) begin
            trap_target_s = vec_base_s + vec_off_s;
        end else begin
            trap_target_s = vec_base_s;
        end
    end

    // Fixed-priority pick of the winning event: trap > mret > sret > mispredict.
    always_comb begin
        target_o = {PC_WIDTH{1'b0}};
        kind_o   = KIND_MISS;
        if (trap_i) begin
            target_o = trap_target_s;
            kind_o   = KIND_TRAP;
        end else if (mret_i) begin
            target_o = {mepc_i[PC_WIDTH-1:2], 2'b00};
            kind_o   = KIND_RET;
        end else if (sret_i) begin
            target_o = {sepc_i[PC_WIDTH-1:2], 2'b00};
            kind_o   = KIND_RET;
        end else if (miss_i) begin
            target_o = miss_pc_i;
            kind_o   = KIND_MISS;
        end else begin
            target_o = {PC_WIDTH{1'b0}};
            kind_o   = KIND_MISS;
        end
    end

endmodule : trap_vec_calc

// File: rtl/trap_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// trap_redirect_ctrl
// Sequences the front-end redirect after a commit-stage control event:
// one-cycle flush, optional wait for back-end drain (traps/returns only),
// then a redirect PC offered to fetch under valid/ready.
//   clk, rstn                       : clock, async active-low reset
//   global_trap_i, trap_is_interrupt_i, trap_to_s_i, csr_ecause_i : trap event
//   csr_mtvec_i, csr_stvec_i        : trap vectors
//   global_mret_i, global_sret_i, csr_mepc_i, csr_sepc_i : return events
//   global_predict_miss_i, predict_miss_pc_i : mispredict event
//   pipe_drained_i                  : back-end idle
//   flush_o                         : one-cycle pipeline kill
//   redirect_valid_o/_pc_o/_kind_o  : redirect offer to fetch
//   redirect_ready_i                : fetch accepts redirect
//   busy_o                          : blocks ROB commit while sequencing
// -----------------------------------------------------------------------------
module trap_redirect_ctrl
    import trap_redirect_ctrl_pkg::*;
#(
    parameter int PC_WIDTH              = 39,
    parameter int XLEN                  = 64,
    parameter int EXCEPTION_CAUSE_WIDTH = 4
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             global_trap_i,
    input  logic                             trap_is_interrupt_i,
    input  logic                             trap_to_s_i,
    input  logic [EXCEPTION_CAUSE_WIDTH-1:0] csr_ecause_i,
    input  logic [XLEN-1:0]                  csr_mtvec_i,
    input  logic [XLEN-1:0]                  csr_stvec_i,
    input  logic                             global_mret_i,
    input  logic                             global_sret_i,
    input  logic [XLEN-1:0]                  csr_mepc_i,
    input  logic [XLEN-1:0]                  csr_sepc_i,
    input  logic                             global_predict_miss_i,
    input  logic [PC_WIDTH-1:0]              predict_miss_pc_i,
    input  logic                             pipe_drained_i,
    output logic                             flush_o,
    output logic                             redirect_valid_o,
    output logic [PC_WIDTH-1:0]              redirect_pc_o,
    input  logic                             redirect_ready_i,
    output logic [1:0]                       redirect_kind_o,
    output logic                             busy_o
);

    state_e              state_q, state_d;
    logic [PC_WIDTH-1:0] target_q, target_d;
    kind_e               kind_q, kind_d;
    logic                flush_q, valid_q, busy_q;

    logic                evt_s;
    logic [PC_WIDTH-1:0] calc_target_s;
    kind_e               calc_kind_s;

    trap_vec_calc #(
        .PC_WIDTH              (PC_WIDTH),
        .XLEN                  (XLEN),
        .EXCEPTION_CAUSE_WIDTH (EXCEPTION_CAUSE_WIDTH)
    ) u_trap_vec_calc (
        .trap_i              (global_trap_i),
        .trap_is_interrupt_i (trap_is_interrupt_i),
        .trap_to_s_i         (trap_to_s_i),
        .ecause_i            (csr_ecause_i),
        .mtvec_i             (csr_mtvec_i),
        .stvec_i             (csr_stvec_i),
        .mret_i              (global_mret_i),
        .sret_i              (global_sret_i),
        .mepc_i              (csr_mepc_i),
        .sepc_i              (csr_sepc_i),
        .miss_i              (global_predict_miss_i),
        .miss_pc_i           (predict_miss_pc_i),
        .event_o             (evt_s),
        .target_o            (calc_target_s),
        .kind_o              (calc_kind_s)
    );

    // Next-state logic; strobes are only looked at in IDLE since commit is blocked otherwise.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        kind_d   = kind_q;
        case (state_q)
            ST_IDLE: begin
                if (evt_s) begin
                    state_d  = ST_FLUSH;
                    target_d = calc_target_s;
                    kind_d   = calc_kind_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                // Mispredicts need no drain: the younger work is simply killed.
                if (kind_q == KIND_MISS) begin
                    state_d = ST_REDIRECT;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_drained_i) begin
                    state_d = ST_REDIRECT;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_REDIRECT: begin
                if (redirect_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REDIRECT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched target/kind and output flops (outputs decoded from next state).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            target_q <= {PC_WIDTH{1'b0}};
            kind_q   <= KIND_MISS;
            flush_q  <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            kind_q   <= kind_d;
            flush_q  <= (state_d == ST_FLUSH);
            valid_q  <= (state_d == ST_REDIRECT);
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    assign flush_o          = flush_q;
    assign redirect_valid_o = valid_q;
    assign busy_o           = busy_q;
    assign redirect_pc_o    = target_q;
    assign redirect_kind_o  = kind_q;

endmodule : trap_redirect_ctrl

// File: tb/tb_trap_redirect_ctrl.sv
// -----------------------------------------------------------------------------
// tb_trap_redirect_ctrl
// Directed scenarios followed by randomized events for trap_redirect_ctrl.
// Expected targets come from arithmetic on the CSR values; expected timing
// comes from the event-to-redirect schedule of each event type.
// -----------------------------------------------------------------------------
module tb_trap_redirect_ctrl;

    localparam int PW = 39;
    localparam int XL = 64;
    localparam int CW = 4;
    localparam logic [63:0] PC_MASK = 64'h0000_007F_FFFF_FFFF;

    logic          clk;
    logic          rstn;
    logic          global_trap_i;
    logic          trap_is_interrupt_i;
    logic          trap_to_s_i;
    logic [CW-1:0] csr_ecause_i;
    logic [XL-1:0] csr_mtvec_i;
    logic [XL-1:0] csr_stvec_i;
    logic          global_mret_i;
    logic          global_sret_i;
    logic [XL-1:0] csr_mepc_i;
    logic [XL-1:0] csr_sepc_i;
    logic          global_predict_miss_i;
    logic [PW-1:0] predict_miss_pc_i;
    logic          pipe_drained_i;
    logic          flush_o;
    logic          redirect_valid_o;
    logic [PW-1:0] redirect_pc_o;
    logic          redirect_ready_i;
    logic [1:0]    redirect_kind_o;
    logic          busy_o;

    int n_cmp;
    int n_bad;

    trap_redirect_ctrl #(.PC_WIDTH(PW), .XLEN(XL), .EXCEPTION_CAUSE_WIDTH(CW)) dut (
        .clk                   (clk),
        .rstn                  (rstn),
        .global_trap_i         (global_trap_i),
        .trap_is_interrupt_i   (trap_is_interrupt_i),
        .trap_to_s_i           (trap_to_s_i),
        .csr_ecause_i          (csr_ecause_i),
        .csr_mtvec_i           (csr_mtvec_i),
        .csr_stvec_i           (csr_stvec_i),
        .global_mret_i         (global_mret_i),
        .global_sret_i         (global_sret_i),
        .csr_mepc_i            (csr_mepc_i),
        .csr_sepc_i            (csr_sepc_i),
        .global_predict_miss_i (global_predict_miss_i),
        .predict_miss_pc_i     (predict_miss_pc_i),
        .pipe_drained_i        (pipe_drained_i),
        .flush_o               (flush_o),
        .redirect_valid_o      (redirect_valid_o),
        .redirect_pc_o         (redirect_pc_o),
        .redirect_ready_i      (redirect_ready_i),
        .redirect_kind_o       (redirect_kind_o),
        .busy_o                (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_strobes();
        global_trap_i         = 1'b0;
        global_mret_i         = 1'b0;
        global_sret_i         = 1'b0;
        global_predict_miss_i = 1'b0;
    endtask

    // Random strobes and payload while busy; none of it may disturb the pending redirect.
    task automatic noise();
        global_trap_i         = 1'($urandom_range(0, 1));
        global_mret_i         = 1'($urandom_range(0, 1));
        global_sret_i         = 1'($urandom_range(0, 1));
        global_predict_miss_i = 1'($urandom_range(0, 1));
        trap_is_interrupt_i   = 1'($urandom_range(0, 1));
        trap_to_s_i           = 1'($urandom_range(0, 1));
        csr_ecause_i          = 4'($urandom);
        csr_mtvec_i           = {32'($urandom), 32'($urandom)};
        csr_stvec_i           = {32'($urandom), 32'($urandom)};
        csr_mepc_i            = {32'($urandom), 32'($urandom)};
        csr_sepc_i            = {32'($urandom), 32'($urandom)};
        predict_miss_pc_i     = PW'({32'($urandom), 32'($urandom)});
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".flush"}, 64'(flush_o), 64'd0);
        check({tag, ".valid"}, 64'(redirect_valid_o), 64'd0);
        check({tag, ".busy"},  64'(busy_o), 64'd0);
    endtask

    // Full event: strobes applied in an IDLE cycle T, drain held low d cycles, ready held low r cycles.
    task automatic run_event(input string tag,
                             input bit tr, input bit intr, input bit tos, input bit mr,
                             input bit sr, input bit ms, input logic [3:0] cause,
                             input logic [63:0] mtvec, input logic [63:0] stvec,
                             input logic [63:0] mepc, input logic [63:0] sepc,
                             input logic [63:0] mpc, input int d, input int r, input bit nz);
        logic [63:0] tvec;
        logic [63:0] exp_pc;
        logic [63:0] exp_kind;
        // Reference: trap > mret > sret > mispredict, targets via plain arithmetic.
        if (tr) begin
            tvec   = tos ? stvec : mtvec;
            exp_pc = (tvec & PC_MASK) - ((tvec & PC_MASK) % 64'd4);
            if ((tvec % 64'd4 == 64'd1) && intr) begin
                exp_pc = (exp_pc + 64'(cause) * 64'd4) & PC_MASK;
            end
            exp_kind = 64'd1;
        end else if (mr) begin
            exp_pc   = (mepc & PC_MASK) - ((mepc & PC_MASK) % 64'd4);
            exp_kind = 64'd2;
        end else if (sr) begin
            exp_pc   = (sepc & PC_MASK) - ((sepc & PC_MASK) % 64'd4);
            exp_kind = 64'd2;
        end else begin
            exp_pc   = mpc & PC_MASK;
            exp_kind = 64'd0;
        end
        // Cycle T
        global_trap_i         = tr;
        trap_is_interrupt_i   = intr;
        trap_to_s_i           = tos;
        global_mret_i         = mr;
        global_sret_i         = sr;
        global_predict_miss_i = ms;
        csr_ecause_i          = cause;
        csr_mtvec_i           = mtvec;
        csr_stvec_i           = stvec;
        csr_mepc_i            = mepc;
        csr_sepc_i            = sepc;
        predict_miss_pc_i     = PW'(mpc);
        redirect_ready_i      = 1'b0;
        pipe_drained_i        = 1'b0;
        step();
        // Cycle T+1: flush
        clear_strobes();
        if (nz) noise();
        check({tag, ".t1_flush"}, 64'(flush_o), 64'd1);
        check({tag, ".t1_busy"},  64'(busy_o), 64'd1);
        check({tag, ".t1_valid"}, 64'(redirect_valid_o), 64'd0);
        // Drain high during flush must not let a trap/ret skip DRAIN.
        pipe_drained_i = 1'b1;
        step();
        // Cycle T+2
        check({tag, ".t2_flush"}, 64'(flush_o), 64'd0);
        check({tag, ".t2_busy"},  64'(busy_o), 64'd1);
        if (exp_kind != 64'd0) begin
            check({tag, ".t2_valid"}, 64'(redirect_valid_o), 64'd0);
            for (int i = 0; i < d; i++) begin
                pipe_drained_i = 1'b0;
                if (nz) noise();
                step();
                check({tag, ".drain_valid"}, 64'(redirect_valid_o), 64'd0);
                check({tag, ".drain_busy"},  64'(busy_o), 64'd1);
            end
            pipe_drained_i = 1'b1;
            step();
        end
        check({tag, ".valid"}, 64'(redirect_valid_o), 64'd1);
        check({tag, ".pc"},    64'(redirect_pc_o), exp_pc);
        check({tag, ".kind"},  64'(redirect_kind_o), exp_kind);
        for (int i = 0; i < r; i++) begin
            redirect_ready_i = 1'b0;
            if (nz) noise();
            step();
            check({tag, ".hold_valid"}, 64'(redirect_valid_o), 64'd1);
            check({tag, ".hold_pc"},    64'(redirect_pc_o), exp_pc);
            check({tag, ".hold_kind"},  64'(redirect_kind_o), exp_kind);
            check({tag, ".hold_flush"}, 64'(flush_o), 64'd0);
        end
        // Handshake cycle H; IDLE at H+1.
        redirect_ready_i = 1'b1;
        clear_strobes();
        step();
        redirect_ready_i = 1'b0;
        pipe_drained_i   = 1'b0;
        check_idle_outputs({tag, ".after"});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rstn  = 1'b0;
        clear_strobes();
        trap_is_interrupt_i = 1'b0;
        trap_to_s_i         = 1'b0;
        csr_ecause_i        = 4'd0;
        csr_mtvec_i         = 64'd0;
        csr_stvec_i         = 64'd0;
        csr_mepc_i          = 64'd0;
        csr_sepc_i          = 64'd0;
        predict_miss_pc_i   = {PW{1'b0}};
        pipe_drained_i      = 1'b0;
        redirect_ready_i    = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        check("reset.pc",   64'(redirect_pc_o), 64'd0);
        check("reset.kind", 64'(redirect_kind_o), 64'd0);
        rstn = 1'b1;
        step();
        check_idle_outputs("idle");

        // Mispredict basic.
        run_event("miss", 0, 0, 0, 0, 0, 1, 4'd0, 64'd0, 64'd0, 64'd0, 64'd0,
                  64'h8000_1000, 0, 0, 0);
        // Vectored interrupt and the same vector with an exception.
        run_event("vint", 1, 1, 0, 0, 0, 0, 4'd7, 64'h8000_0001, 64'd0, 64'd0, 64'd0,
                  64'd0, 0, 0, 0);
        run_event("vexc", 1, 0, 0, 0, 0, 0, 4'd7, 64'h8000_0001, 64'd0, 64'd0, 64'd0,
                  64'd0, 0, 0, 0);
        // Delegated trap with drain held low five cycles.
        run_event("deleg", 1, 0, 1, 0, 0, 0, 4'd2, 64'h1234_0001, 64'h8020_0000, 64'd0,
                  64'd0, 64'd0, 5, 0, 0);
        // Trap and mispredict together; strobes while busy.
        run_event("tr_ms", 1, 0, 0, 0, 0, 1, 4'd3, 64'h8000_0400, 64'd0, 64'd0, 64'd0,
                  64'h8000_2000, 1, 1, 1);
        // mret with ready held low three cycles.
        run_event("mret", 0, 0, 0, 1, 0, 0, 4'd0, 64'd0, 64'd0, 64'h8000_0106, 64'd0,
                  64'd0, 0, 3, 0);
        // sret beats mispredict; mret beats sret.
        run_event("sret", 0, 0, 0, 0, 1, 1, 4'd0, 64'd0, 64'd0, 64'h1111_1110,
                  64'h8040_0007, 64'h8000_3000, 2, 1, 0);
        run_event("mr_sr", 0, 0, 0, 1, 1, 0, 4'd0, 64'd0, 64'd0, 64'h8000_0203,
                  64'h8040_0000, 64'd0, 0, 0, 0);
        // Vector add wrapping past the PC width, and upper CSR bits ignored.
        run_event("wrap", 1, 1, 0, 0, 0, 0, 4'd15, 64'hFFFF_FF7F_FFFF_FFFD, 64'd0, 64'd0,
                  64'd0, 64'd0, 0, 0, 0);
        // Mode 3 treated as direct even for an interrupt.
        run_event("mode3", 1, 1, 1, 0, 0, 0, 4'd9, 64'd0, 64'h8000_0803, 64'd0, 64'd0,
                  64'd0, 0, 0, 0);

        // Reset asserted while waiting in DRAIN.
        global_trap_i = 1'b1;
        csr_mtvec_i   = 64'h8000_0000;
        step();
        clear_strobes();
        pipe_drained_i = 1'b0;
        step();
        #2;
        rstn = 1'b0;
        #1;
        check_idle_outputs("rst_mid");
        check("rst_mid.pc",   64'(redirect_pc_o), 64'd0);
        check("rst_mid.kind", 64'(redirect_kind_o), 64'd0);
        step();
        pipe_drained_i = 1'b1;
        step();
        rstn = 1'b1;
        pipe_drained_i = 1'b0;
        step();
        check_idle_outputs("rst_rel");
        run_event("miss2", 0, 0, 0, 0, 0, 1, 4'd0, 64'd0, 64'd0, 64'd0, 64'd0,
                  64'h8000_1000, 0, 0, 0);

        // Randomized events.
        for (int k = 0; k < 40; k++) begin
            bit tr, mr, sr, ms;
            tr = 1'($urandom_range(0, 3) == 0);
            mr = 1'($urandom_range(0, 3) == 0);
            sr = 1'($urandom_range(0, 3) == 0);
            ms = 1'($urandom_range(0, 1));
            if (!(tr || mr || sr || ms)) ms = 1'b1;
            run_event("rand", tr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mr, sr, ms,
                      4'($urandom),
                      {32'($urandom), 30'($urandom), 2'($urandom_range(0, 3))},
                      {32'($urandom), 30'($urandom), 2'($urandom_range(0, 3))},
                      {32'($urandom), 32'($urandom)}, {32'($urandom), 32'($urandom)},
                      {32'($urandom), 32'($urandom)},
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_trap_redirect_ctrl
